// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite responder owning a word-addressed on-chip memory, with independent read and write FSMs.
// Optional macro RANDOM_DELAY_EN adds LFSR-driven random response latency.
module axi_lite_mem_responder #(
    parameter logic [31:0] BASE  = 32'h8000_0000,
    parameter int unsigned AW    = 12,
    parameter int unsigned DLY_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int unsigned DEPTH       = 1 << AW;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

    logic [31:0] mem_q [DEPTH];

    // Unsigned offset wraps for addresses below BASE, so one compare covers both bounds.
    function automatic logic addr_hit(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off >> (AW + 2)) == 32'd0;
    endfunction

    function automatic logic [AW-1:0] addr_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return AW'(off >> 2);
    endfunction

    logic [DLY_W-1:0] new_dly;
`ifdef RANDOM_DELAY_EN
    logic [7:0] lfsr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= 8'hA5;
        else     lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
    assign new_dly = lfsr_q[DLY_W-1:0];
`else
    assign new_dly = '0;
`endif

    logic unused_wstrb;
    assign unused_wstrb = ^wstrb[7:4];

    // ---------------- read channel ----------------
    r_state_e         r_state_q, r_state_d;
    logic [31:0]      araddr_q, araddr_d;
    logic [DLY_W-1:0] r_cnt_q, r_cnt_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;
    logic             arready_q, arready_d;
    logic [31:0]      rd_addr;
    logic             rd_go;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            araddr_q  <= '0;
            r_cnt_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            arready_q <= 1'b1;
        end else begin
            r_state_q <= r_state_d;
            araddr_q  <= araddr_d;
            r_cnt_q   <= r_cnt_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            arready_q <= arready_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        r_cnt_d   = r_cnt_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rd_addr   = araddr_q;
        rd_go     = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    araddr_d = araddr;
                    rd_addr  = araddr;
                    if (new_dly == '0) begin
                        rd_go = 1'b1;
                    end else begin
                        r_state_d = R_WAIT;
                        r_cnt_d   = new_dly;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt_q == DLY_W'(1)) rd_go = 1'b1;
                else                      r_cnt_d = r_cnt_q - DLY_W'(1);
            end
            R_RESP: begin
                if (rready) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // Memory is sampled on the edge that enters R_RESP.
        if (rd_go) begin
            r_state_d = R_RESP;
            rvalid_d  = 1'b1;
            if (addr_hit(rd_addr)) begin
                rdata_d = mem_q[addr_idx(rd_addr)];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end
        end
        arready_d = (r_state_d == R_IDLE);
    end

    // ---------------- write channel ----------------
    w_state_e         w_state_q, w_state_d;
    logic             aw_held_q, aw_held_d;
    logic             w_held_q, w_held_d;
    logic [31:0]      awaddr_q, awaddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [DLY_W-1:0] w_cnt_q, w_cnt_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             awready_q, awready_d;
    logic             wready_q, wready_d;
    logic [31:0]      wr_addr, wr_data;
    logic [3:0]       wr_strb;
    logic             wr_go, wr_en;
    logic [AW-1:0]    wr_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            w_cnt_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            w_cnt_q   <= w_cnt_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        w_cnt_d   = w_cnt_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_addr   = awaddr_q;
        wr_data   = wdata_q;
        wr_strb   = wstrb_q;
        wr_go     = 1'b0;
        wr_en     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = awaddr;
                    wr_addr   = awaddr;
                end
                if (wvalid && wready_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = wdata;
                    wstrb_d  = wstrb[3:0];
                    wr_data  = wdata;
                    wr_strb  = wstrb[3:0];
                end
                // The later of the two handshakes (or both together) launches the write.
                if (aw_held_d && w_held_d) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    if (new_dly == '0) begin
                        wr_go = 1'b1;
                    end else begin
                        w_state_d = W_WAIT;
                        w_cnt_d   = new_dly;
                    end
                end
            end
            W_WAIT: begin
                if (w_cnt_q == DLY_W'(1)) wr_go = 1'b1;
                else                      w_cnt_d = w_cnt_q - DLY_W'(1);
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (wr_go) begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
            if (addr_hit(wr_addr)) begin
                wr_en   = 1'b1;
                bresp_d = RESP_OKAY;
            end else begin
                bresp_d = RESP_SLVERR;
            end
        end
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    end

    assign wr_idx = addr_idx(wr_addr);

    // Commit shares the edge with a same-cycle read sample, which therefore sees old data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

endmodule
